flag_cond_unit: RTL and testbench

FLAG_COND_UNIT -- requirements
Module: flag_cond_unit

---
 rtl/flag_cond_unit.sv | 58 +++++
 tb/tb_flag_cond_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/flag_cond_unit.sv
// flag_cond_unit: one-deep result register that evaluates the condition code against
// the architectural NZCV flags, conditionally updates them and counts retired results.
module flag_cond_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_co,
  input  logic             alu_ovf,
  input  logic [2:0]       alu_ctrl,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s_bit,
  input  logic [3:0]       cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             cond_pass,
  output logic [3:0]       flags_q,
  output logic             cond_err,
  output logic [15:0]      retire_cnt
);
  logic n, z, c, v, pass, acc;
  logic [7:0] base;
  assign {n, z, c, v} = flags_q;
  assign in_ready = !reset && (!out_valid || out_ready);
  assign acc = in_valid && in_ready;
  // odd codes are the complement of the even code below them; 1111 is "never"
  assign base = {1'b1, !z && (n == v), n == v, c && !z, v, n, c, z};
  assign pass = base[cond[3:1]] ^ cond[0];
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      alu_out    <= '0;
      cond_pass  <= 1'b0;
      flags_q    <= 4'b0000;
      cond_err   <= 1'b0;
      retire_cnt <= 16'd0;
    end else begin
      cond_err <= acc && (cond == 4'hf);
      if (out_valid && out_ready && cond_pass) retire_cnt <= retire_cnt + 16'd1;
      if (acc) begin
        alu_out   <= alu_y;
        cond_pass <= pass;
        out_valid <= 1'b1;
        if (s_bit && pass) begin
          flags_q[3:2] <= {alu_n, alu_z};
          if (alu_ctrl <= 3'd2) flags_q[1:0] <= {alu_co, alu_ovf};
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_flag_cond_unit.sv
// tb_flag_cond_unit: directed checks of the named scenarios plus randomized traffic
// compared every cycle against a behavioural model of the flag/condition unit.
module tb_flag_cond_unit;
  logic clk = 0, reset = 1;
  logic [7:0] alu_y = 0;
  logic alu_n = 0, alu_z = 0, alu_co = 0, alu_ovf = 0;
  logic [2:0] alu_ctrl = 0;
  logic in_valid = 0, in_ready, s_bit = 0;
  logic [3:0] cond = 0;
  logic out_valid, out_ready = 0;
  logic [7:0] alu_out;
  logic cond_pass, cond_err;
  logic [3:0] flags_q;
  logic [15:0] retire_cnt;
  int tests = 0, fails = 0;

  flag_cond_unit #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .alu_y(alu_y), .alu_n(alu_n), .alu_z(alu_z),
    .alu_co(alu_co), .alu_ovf(alu_ovf), .alu_ctrl(alu_ctrl), .in_valid(in_valid),
    .in_ready(in_ready), .s_bit(s_bit), .cond(cond), .out_valid(out_valid),
    .out_ready(out_ready), .alu_out(alu_out), .cond_pass(cond_pass), .flags_q(flags_q),
    .cond_err(cond_err), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Condition table written straight from the architectural definitions.
  function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
    logic fn, fz, fc, fv;
    {fn, fz, fc, fv} = f;
    case (cc)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fc;
      4'd3:  return !fc;
      4'd4:  return fn;
      4'd5:  return !fn;
      4'd6:  return fv;
      4'd7:  return !fv;
      4'd8:  return fc && !fz;
      4'd9:  return !fc || fz;
      4'd10: return fn == fv;
      4'd11: return fn != fv;
      4'd12: return !fz && (fn == fv);
      4'd13: return fz || (fn != fv);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic m_valid = 0, m_pass = 0, m_err = 0;
  logic [7:0] m_y = 0;
  logic [3:0] m_flags = 0;
  int m_cnt = 0;

  always @(posedge clk) begin
    logic take, p;
    if (reset) begin
      m_valid = 0; m_pass = 0; m_err = 0; m_y = 0; m_flags = 0; m_cnt = 0;
    end else begin
      take = in_valid && (!m_valid || out_ready);
      if (m_valid && out_ready && m_pass) m_cnt = (m_cnt + 1) % 65536;
      m_err = take && cond == 4'hf;
      if (take) begin
        p = cond_ok(cond, m_flags);
        m_y = alu_y; m_pass = p; m_valid = 1;
        if (s_bit && p) begin
          m_flags[3] = alu_n;
          m_flags[2] = alu_z;
          if (alu_ctrl < 3) begin m_flags[1] = alu_co; m_flags[0] = alu_ovf; end
        end
      end else if (m_valid && out_ready) m_valid = 0;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, !reset && (!m_valid || out_ready));
    chk("out_valid", out_valid, m_valid);
    chk("flags_q", flags_q, m_flags);
    chk("cond_err", cond_err, m_err);
    chk("retire_cnt", retire_cnt, m_cnt);
    if (m_valid) begin
      chk("alu_out", alu_out, m_y);
      chk("cond_pass", cond_pass, m_pass);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [7:0] y, input logic n, z, co, ovf,
                    input logic [2:0] ctl, input logic s, input logic [3:0] cc);
    in_valid = 1; alu_y = y; alu_n = n; alu_z = z; alu_co = co; alu_ovf = ovf;
    alu_ctrl = ctl; s_bit = s; cond = cc;
  endtask

  initial begin
    logic [15:0] c0;
    reset = 1; in_valid = 1; out_ready = 1;
    tick(); tick();
    chk("rst out_valid", out_valid, 0);
    chk("rst flags", flags_q, 0);
    chk("rst cnt", retire_cnt, 0);
    chk("rst in_ready", in_ready, 0);
    reset = 0; in_valid = 0;
    tick();
    chk("post-rst in_ready", in_ready, 1);
    op(8'h80, 1, 0, 0, 1, 3'b000, 1, 4'b1110);
    tick();
    chk("add alu_out", alu_out, 8'h80);
    chk("add flags", flags_q, 4'b1001);
    chk("add pass", cond_pass, 1);
    op(8'h11, 0, 1, 0, 0, 3'b000, 1, 4'b1011);
    tick();
    chk("lt pass", cond_pass, 0);
    chk("lt flags", flags_q, 4'b1001);
    chk("lt cnt", retire_cnt, 1);
    in_valid = 0;
    tick();
    chk("fail retire cnt", retire_cnt, 1);
    op(8'h00, 0, 1, 1, 0, 3'b100, 1, 4'b1110);
    tick();
    chk("logic flags", flags_q, 4'b0101);
    out_ready = 0;
    op(8'h5a, 0, 0, 0, 0, 3'b000, 0, 4'b1110);
    tick();
    chk("bp in_ready", in_ready, 0);
    chk("bp alu_out", alu_out, 8'h00);
    tick();
    chk("bp in_ready 2", in_ready, 0);
    chk("bp alu_out 2", alu_out, 8'h00);
    c0 = retire_cnt;
    out_ready = 1;
    tick();
    chk("bp new out", alu_out, 8'h5a);
    chk("bp out_valid", out_valid, 1);
    chk("bp cnt", retire_cnt, c0 + 16'd1);
    op(8'h33, 1, 1, 1, 1, 3'b000, 1, 4'b1111);
    tick();
    chk("rsv err", cond_err, 1);
    chk("rsv pass", cond_pass, 0);
    chk("rsv flags", flags_q, 4'b0101);
    in_valid = 0;
    tick();
    chk("rsv err drop", cond_err, 0);
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      alu_y = 8'($urandom);
      {alu_n, alu_z, alu_co, alu_ovf} = 4'($urandom);
      alu_ctrl = 3'($urandom);
      s_bit = 1'($urandom);
      cond = 4'($urandom);
      tick();
    end
    reset = 0; in_valid = 1; out_ready = 1; cond = 4'b1110; s_bit = 0;
    tick();
    c0 = retire_cnt;
    for (int i = 0; i < 65536; i++) tick();
    chk("cnt wrap", retire_cnt, c0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
